encoder8x3_sequential_model: RTL

Sequential 8-to-3 encoder: captures an 8-bit request vector and emits the 3-bit binary code {a,b,c} of every set bit, one code per accepted beat, under a valid/ready handshake. It is the encoding counterpart to the team's 3x8 decoder: each emitted code, fed into that decoder with enable=1, reproduces the one-hot bit it came from. It serves as the request-serialising front end ahead of decoder-driven select logic.

---
 rtl/encoder8x3_sequential_model.sv | 76 +++++++
 1 files changed

// File: rtl/encoder8x3_sequential_model.sv
// Sequential 8-to-3 encoder: captures a request vector and serialises the binary index of each
// set bit, one code per valid/ready handshake, in priority order.
module encoder8x3_sequential_model #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       load,
  input  logic [7:0] d,
  input  logic       ready,
  output logic       valid,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       last,
  output logic       busy,
  output logic       none
);

  logic [7:0] pend_q, pend_d;
  logic       none_q, none_d;
  logic [2:0] sel;
  logic [7:0] sel_onehot;
  logic       load_ok;

  // Index of the bit to emit next; scan order makes the last hit win.
  always_comb begin
    sel = 3'd0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (pend_q[i]) sel = i[2:0];
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_q[i]) sel = i[2:0];
      end
    end
  end

  assign sel_onehot = 8'b0000_0001 << sel;
  assign busy       = (pend_q != 8'h00);
  assign load_ok    = load && !busy;

  always_comb begin
    pend_d = pend_q;
    none_d = 1'b0;
    if (!enable) begin
      pend_d = 8'h00;
    end else if (busy) begin
      if (ready) pend_d = pend_q & ~sel_onehot;
    end else if (load_ok) begin
      pend_d = d;
      none_d = (d == 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 8'h00;
      none_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      none_q <= none_d;
    end
  end

  // Outputs decode from registered state only; zero whenever nothing is pending.
  always_comb begin
    valid     = busy;
    {a, b, c} = busy ? sel : 3'b000;
    last      = busy && ((pend_q & (pend_q - 8'd1)) == 8'h00);
    none      = none_q;
  end

endmodule
